uart_host_bridge: RTL and testbench

// - Host-side peer of the UART core: drives its parallel TX/config inputs, collects its parallel RX outputs.
// - Buffers host TX words in a FIFO; runs the core's valid/ready handshake one word at a time.
// - Captures each received word, with its error flag, into an RX FIFO. Sequences config updates (store pulse).

---
 rtl/uart_host_bridge_if.sv | 24 ++
 rtl/uart_host_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_uart_host_bridge.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_host_bridge_if.sv
// Core-side bus between the host bridge and the UART core: config, TX handshake, RX word.
// Latency: none, plain wires.
// Backpressure: TX uses valid/ready with ready low meaning the core has taken the word.
interface uart_host_bridge_if;
  logic [10:0] o_uart_config;
  logic        o_uart_tx_valid;
  logic [8:0]  o_uart_tx_parallel;
  logic        i_uart_tx_ready;
  logic [8:0]  i_uart_rx_parallel;
  logic        i_uart_rx_valid;
  logic        i_uart_rx_error;

  // Bridge side
  modport master (
    output o_uart_config, o_uart_tx_valid, o_uart_tx_parallel,
    input  i_uart_tx_ready, i_uart_rx_parallel, i_uart_rx_valid, i_uart_rx_error
  );

  // UART core side
  modport slave (
    input  o_uart_config, o_uart_tx_valid, o_uart_tx_parallel,
    output i_uart_tx_ready, i_uart_rx_parallel, i_uart_rx_valid, i_uart_rx_error
  );
endinterface

// File: rtl/uart_host_bridge.sv
// Host bridge for the UART core: TX FIFO + one-word handshake, RX capture FIFO, config store sequencer.
// Latency: host push/pop -> status 1 cycle; RX valid rise -> o_rx_empty low 2 cycles.
// Backpressure: host pushes dropped when o_tx_full; RX words dropped (sticky overflow) on full RX FIFO.
// Optional: UART_BRIDGE_ERR_FILTER_EN discards words received with the error flag set.
module uart_host_bridge #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CFG_HOLD   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [8:0] i_tx_data,
  input  logic       i_tx_push,
  output logic       o_tx_full,
  output logic [8:0] o_rx_data,
  output logic       o_rx_err,
  input  logic       i_rx_pop,
  output logic       o_rx_empty,
  output logic       o_rx_overflow,
  input  logic [9:0] i_cfg,
  input  logic       i_cfg_load,
  output logic       o_cfg_busy,
  uart_host_bridge_if.master uart
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam int HW = $clog2(CFG_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(CFG_HOLD - 1);
  // baud 0000, stop 1, parity 1, size 8
  localparam logic [9:0] CFG_RESET = 10'b0000_1_1_1000;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, CFG} state_t;

  // ---------------- TX FIFO ----------------
  logic [8:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [DEPTH_LOG2:0]   tx_count;
  logic tx_empty, tx_full, tx_push_ok, tx_pop, tx_pop_ok;

  assign tx_empty   = (tx_count == '0);
  assign tx_full    = (tx_count == FULL_CNT);
  // Full is judged before any same-cycle pop, so a push into a full FIFO is always refused.
  assign tx_push_ok = i_tx_push && !tx_full;
  assign tx_pop_ok  = tx_pop && !tx_empty;
  assign o_tx_full  = tx_full;

  // TX storage write
  always_ff @(posedge i_clk) begin
    if (tx_push_ok) tx_mem[tx_wr_ptr] <= i_tx_data;
  end

  // TX pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push_ok) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop_ok)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push_ok, tx_pop_ok})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------- TX / config FSM ----------------
  state_t     state, state_nxt;
  logic [8:0] tx_dat;
  logic [9:0] cfg_lat, cfg_out;
  logic       cfg_pend;
  logic [HW-1:0] hold_cnt;
  logic       cfg_enter;

  assign cfg_enter = (state == IDLE) && (state_nxt == CFG);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state; a pending config wins over queued TX words, but only once the core is idle
  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_pend) begin
          state_nxt = CFG;
        end else if (!tx_empty && uart.i_uart_tx_ready) begin
          state_nxt = REQ;
          tx_pop    = 1'b1;
        end
      end
      REQ:     if (!uart.i_uart_tx_ready) state_nxt = DRAIN;
      DRAIN:   if (uart.i_uart_tx_ready)  state_nxt = IDLE;
      CFG:     if (hold_cnt == HOLD_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; data and config bits come from registers so they stay steady
  always_comb begin
    uart.o_uart_tx_valid    = (state == REQ);
    uart.o_uart_tx_parallel = tx_dat;
    uart.o_uart_config      = {cfg_out, (state == CFG)};
    o_cfg_busy              = cfg_pend || (state == CFG);
  end

  // Word, config latch and hold counter registers driven by the FSM
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_dat   <= '0;
      cfg_lat  <= CFG_RESET;
      cfg_out  <= CFG_RESET;
      cfg_pend <= 1'b0;
      hold_cnt <= '0;
    end else begin
      if (tx_pop_ok) tx_dat <= tx_mem[tx_rd_ptr];
      // A new load overrides the pending value; entering CFG consumes the request.
      if (i_cfg_load) begin
        cfg_lat  <= i_cfg;
        cfg_pend <= 1'b1;
      end else if (cfg_enter) begin
        cfg_pend <= 1'b0;
      end
      if (cfg_enter) begin
        cfg_out  <= cfg_lat;
        hold_cnt <= '0;
      end else if (state == CFG) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // ---------------- RX capture + FIFO ----------------
  logic       rx_valid_q, cap_vld, cap_keep;
  logic [9:0] cap_dat;
  logic [9:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [DEPTH_LOG2:0]   rx_count;
  logic rx_empty, rx_full, rx_push_ok, rx_pop_ok;
  logic [9:0] rx_head;

`ifdef UART_BRIDGE_ERR_FILTER_EN
  assign cap_keep = cap_vld && !cap_dat[9];
`else
  assign cap_keep = cap_vld;
`endif

  assign rx_empty   = (rx_count == '0);
  assign rx_full    = (rx_count == FULL_CNT);
  assign rx_push_ok = cap_keep && !rx_full;
  assign rx_pop_ok  = i_rx_pop && !rx_empty;
  assign rx_head    = rx_empty ? 10'd0 : rx_mem[rx_rd_ptr];
  assign o_rx_empty = rx_empty;
  assign o_rx_data  = rx_head[8:0];
`ifdef UART_BRIDGE_ERR_FILTER_EN
  assign o_rx_err   = 1'b0;
`else
  assign o_rx_err   = rx_head[9];
`endif

  // Rising edge of core RX valid captures one {error, data} word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_valid_q <= 1'b0;
      cap_vld    <= 1'b0;
      cap_dat    <= '0;
    end else begin
      rx_valid_q <= uart.i_uart_rx_valid;
      cap_vld    <= uart.i_uart_rx_valid && !rx_valid_q;
      if (uart.i_uart_rx_valid && !rx_valid_q)
        cap_dat <= {uart.i_uart_rx_error, uart.i_uart_rx_parallel};
    end
  end

  // RX storage write
  always_ff @(posedge i_clk) begin
    if (rx_push_ok) rx_mem[rx_wr_ptr] <= cap_dat;
  end

  // RX pointers, occupancy and sticky overflow (set wins over a same-cycle clear)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      rx_count      <= '0;
      o_rx_overflow <= 1'b0;
    end else begin
      if (rx_push_ok) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop_ok)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push_ok, rx_pop_ok})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
      if (cap_keep && rx_full) o_rx_overflow <= 1'b1;
      else if (i_cfg_load)     o_rx_overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_host_bridge.sv
// Testbench for uart_host_bridge: table-driven RX vectors plus directed TX/config/overflow sequences.
// Latency: drives and samples on the falling clock edge.
// Backpressure: a small UART core model drops ready 3 cycles after valid and raises it 20 cycles later.
module tb_uart_host_bridge;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [8:0] i_tx_data = '0;
  logic       i_tx_push = 1'b0;
  logic       o_tx_full;
  logic [8:0] o_rx_data;
  logic       o_rx_err;
  logic       i_rx_pop = 1'b0;
  logic       o_rx_empty;
  logic       o_rx_overflow;
  logic [9:0] i_cfg = '0;
  logic       i_cfg_load = 1'b0;
  logic       o_cfg_busy;

  int checks = 0;
  int errors = 0;

  // Core model state
  logic       core_en = 1'b0;
  logic       force_ready = 1'b1;
  logic       model_ready = 1'b1;
  int         vcnt = 0, dcnt = 0, rdy_age = 100;
  int         stab_err = 0, early_err = 0;
  logic [8:0] held = '0;
  logic [8:0] got [$];

  uart_host_bridge_if uart_bus();

  assign uart_bus.i_uart_tx_ready = core_en ? model_ready : force_ready;

  uart_host_bridge #(.DEPTH_LOG2(4), .CFG_HOLD(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_tx_data    (i_tx_data),
    .i_tx_push    (i_tx_push),
    .o_tx_full    (o_tx_full),
    .o_rx_data    (o_rx_data),
    .o_rx_err     (o_rx_err),
    .i_rx_pop     (i_rx_pop),
    .o_rx_empty   (o_rx_empty),
    .o_rx_overflow(o_rx_overflow),
    .i_cfg        (i_cfg),
    .i_cfg_load   (i_cfg_load),
    .o_cfg_busy   (o_cfg_busy),
    .uart         (uart_bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // UART core model: accepts a word after seeing valid for 3 cycles, busy for 20 cycles after that
  initial begin
    forever begin
      @(negedge i_clk);
      if (!core_en) begin
        model_ready = 1'b1;
        vcnt = 0;
        dcnt = 0;
        rdy_age = 100;
      end else if (model_ready) begin
        rdy_age++;
        if (uart_bus.o_uart_tx_valid) begin
          if (rdy_age < 2) early_err++;
          if (vcnt == 0) held = uart_bus.o_uart_tx_parallel;
          else if (uart_bus.o_uart_tx_parallel != held) stab_err++;
          vcnt++;
          if (vcnt == 3) begin
            got.push_back(held);
            model_ready = 1'b0;
            vcnt = 0;
            dcnt = 0;
          end
        end
      end else begin
        dcnt++;
        if (dcnt == 20) begin
          model_ready = 1'b1;
          rdy_age = 0;
        end
      end
    end
  end

  typedef struct {
    logic [8:0] data;
    logic       err;
    logic       present;
    logic [8:0] exp_data;
    logic       exp_err;
  } rx_vec_t;

  rx_vec_t rxv [4];

  initial begin
    int n;
    logic [31:0] w;

    rxv[0] = '{data: 9'h0A5, err: 1'b0, present: 1'b1, exp_data: 9'h0A5, exp_err: 1'b0};
`ifdef UART_BRIDGE_ERR_FILTER_EN
    rxv[1] = '{data: 9'h1FF, err: 1'b1, present: 1'b0, exp_data: 9'h000, exp_err: 1'b0};
    rxv[3] = '{data: 9'h155, err: 1'b1, present: 1'b0, exp_data: 9'h000, exp_err: 1'b0};
`else
    rxv[1] = '{data: 9'h1FF, err: 1'b1, present: 1'b1, exp_data: 9'h1FF, exp_err: 1'b1};
    rxv[3] = '{data: 9'h155, err: 1'b1, present: 1'b1, exp_data: 9'h155, exp_err: 1'b1};
`endif
    rxv[2] = '{data: 9'h000, err: 1'b0, present: 1'b1, exp_data: 9'h000, exp_err: 1'b0};

    uart_bus.i_uart_rx_parallel = '0;
    uart_bus.i_uart_rx_valid    = 1'b0;
    uart_bus.i_uart_rx_error    = 1'b0;

    // Reset values while held in reset, then async deassert mid-cycle
    #12;
    check("rst_config", uart_bus.o_uart_config, 32'h070);
    check("rst_tx_valid", uart_bus.o_uart_tx_valid, 0);
    check("rst_tx_parallel", uart_bus.o_uart_tx_parallel, 0);
    check("rst_rx_empty", o_rx_empty, 1);
    check("rst_tx_full", o_tx_full, 0);
    check("rst_overflow", o_rx_overflow, 0);
    check("rst_busy", o_cfg_busy, 0);
    check("rst_rx_data", o_rx_data, 0);
    check("rst_rx_err", o_rx_err, 0);
    #10 i_rst_n = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);

    // RX capture vectors
    for (int i = 0; i < 4; i++) begin
      uart_bus.i_uart_rx_parallel = rxv[i].data;
      uart_bus.i_uart_rx_error    = rxv[i].err;
      uart_bus.i_uart_rx_valid    = 1'b1;
      @(negedge i_clk);
      uart_bus.i_uart_rx_valid    = 1'b0;
      check("rx_empty_after_1cyc", o_rx_empty, 1);
      @(negedge i_clk);
      check("rx_empty_after_2cyc", o_rx_empty, !rxv[i].present);
      check("rx_head_data", o_rx_data, rxv[i].exp_data);
      check("rx_head_err", o_rx_err, rxv[i].exp_err);
      i_rx_pop = 1'b1;
      @(negedge i_clk);
      i_rx_pop = 1'b0;
      check("rx_empty_after_pop", o_rx_empty, 1);
    end
    uart_bus.i_uart_rx_error = 1'b0;

    // Valid held high for several cycles stores only one word
    uart_bus.i_uart_rx_parallel = 9'h0C3;
    uart_bus.i_uart_rx_valid    = 1'b1;
    repeat (5) @(negedge i_clk);
    uart_bus.i_uart_rx_valid    = 1'b0;
    repeat (2) @(negedge i_clk);
    check("level_head", o_rx_data, 9'h0C3);
    i_rx_pop = 1'b1;
    @(negedge i_clk);
    i_rx_pop = 1'b0;
    check("level_single_push", o_rx_empty, 1);

    // 17 words into a 16-deep RX FIFO
    for (int i = 0; i < 17; i++) begin
      uart_bus.i_uart_rx_parallel = 9'(i * 3 + 1);
      uart_bus.i_uart_rx_valid    = 1'b1;
      @(negedge i_clk);
      uart_bus.i_uart_rx_valid    = 1'b0;
      @(negedge i_clk);
    end
    repeat (2) @(negedge i_clk);
    check("rx_overflow_set", o_rx_overflow, 1);
    for (int i = 0; i < 16; i++) begin
      check("rx_fifo_order", o_rx_data, 32'(i * 3 + 1));
      i_rx_pop = 1'b1;
      @(negedge i_clk);
    end
    i_rx_pop = 1'b0;
    check("rx_empty_after_16", o_rx_empty, 1);
    check("rx_overflow_sticky", o_rx_overflow, 1);

    // Config load clears overflow and runs a store sequence
    i_cfg      = 10'h038;
    i_cfg_load = 1'b1;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
    check("overflow_cleared", o_rx_overflow, 0);
    check("busy_after_load", o_cfg_busy, 1);
    n = 0;
    while (o_cfg_busy && n < 20) begin @(negedge i_clk); n++; end
    check("busy_clear_timeout", 32'(n < 20), 1);
    check("config_after_default_load", uart_bus.o_uart_config, 32'h070);

    // Two TX words through the core model
    core_en = 1'b1;
    i_tx_data = 9'h0A5; i_tx_push = 1'b1;
    @(negedge i_clk);
    i_tx_data = 9'h13C;
    @(negedge i_clk);
    i_tx_push = 1'b0;
    n = 0;
    while (got.size() < 2 && n < 200) begin @(negedge i_clk); n++; end
    check("tx_two_timeout", 32'(n < 200), 1);
    w = (got.size() > 0) ? 32'(got[0]) : 32'hFFFF;
    check("tx_word0", w, 32'h0A5);
    w = (got.size() > 1) ? 32'(got[1]) : 32'hFFFF;
    check("tx_word1", w, 32'h13C);
    n = 0;
    while (!model_ready && n < 40) begin @(negedge i_clk); n++; end
    repeat (2) @(negedge i_clk);

    // Config load while a word is in REQ: word completes, then store pulse
    i_tx_data = 9'h077; i_tx_push = 1'b1;
    @(negedge i_clk);
    i_tx_push = 1'b0;
    n = 0;
    while (!uart_bus.o_uart_tx_valid && n < 20) begin @(negedge i_clk); n++; end
    check("req_valid_timeout", 32'(n < 20), 1);
    i_cfg = 10'h250; i_cfg_load = 1'b1;
    @(negedge i_clk);
    i_cfg_load = 1'b0;
    check("busy_pending", o_cfg_busy, 1);
    check("config_held_during_req", uart_bus.o_uart_config, 32'h070);
    n = 0;
    while (!uart_bus.o_uart_config[0] && n < 100) begin @(negedge i_clk); n++; end
    check("store_timeout", 32'(n < 100), 1);
    check("word_done_before_cfg", got.size(), 3);
    w = (got.size() > 2) ? 32'(got[2]) : 32'hFFFF;
    check("tx_word2", w, 32'h077);
    for (int k = 0; k < 4; k++) begin
      check("cfg_store_high", uart_bus.o_uart_config, 32'h4A1);
      check("cfg_busy_high", o_cfg_busy, 1);
      check("no_valid_in_cfg", uart_bus.o_uart_tx_valid, 0);
      @(negedge i_clk);
    end
    check("cfg_store_low", uart_bus.o_uart_config, 32'h4A0);
    check("cfg_busy_low", o_cfg_busy, 0);
    check("tx_data_stable", stab_err, 0);
    check("valid_after_ready", early_err, 0);

    // Fill TX FIFO with the core stalled, then push and pop on the same cycle
    core_en = 1'b0; force_ready = 1'b0;
    @(negedge i_clk);
    got.delete();
    for (int i = 0; i < 16; i++) begin
      i_tx_data = 9'(i + 9'h100); i_tx_push = 1'b1;
      @(negedge i_clk);
    end
    i_tx_push = 1'b0;
    check("tx_full_16", o_tx_full, 1);
    i_tx_data = 9'h1AA; i_tx_push = 1'b1; force_ready = 1'b1;
    @(negedge i_clk);
    i_tx_push = 1'b0;
    check("tx_full_after_pushpop", o_tx_full, 0);
    core_en = 1'b1;
    n = 0;
    while (got.size() < 16 && n < 800) begin @(negedge i_clk); n++; end
    check("tx_drain_timeout", 32'(n < 800), 1);
    repeat (60) @(negedge i_clk);
    check("tx_rejected_push_absent", got.size(), 16);
    for (int i = 0; i < 16; i++) begin
      w = (got.size() > i) ? 32'(got[i]) : 32'hFFFF;
      check("tx_full_order", w, 32'(i + 9'h100));
    end

    // Async reset mid-operation discards everything immediately
    uart_bus.i_uart_rx_parallel = 9'h033;
    uart_bus.i_uart_rx_valid    = 1'b1;
    @(negedge i_clk);
    uart_bus.i_uart_rx_valid    = 1'b0;
    i_tx_data = 9'h055; i_tx_push = 1'b1;
    @(negedge i_clk);
    i_tx_push = 1'b0;
    check("pre_reset_rx_nonempty", o_rx_empty, 0);
    n = 0;
    while (!uart_bus.o_uart_tx_valid && n < 40) begin @(negedge i_clk); n++; end
    check("pre_reset_valid_timeout", 32'(n < 40), 1);
    #2 i_rst_n = 1'b0;
    #1;
    check("midrst_rx_empty", o_rx_empty, 1);
    check("midrst_tx_valid", uart_bus.o_uart_tx_valid, 0);
    check("midrst_tx_parallel", uart_bus.o_uart_tx_parallel, 0);
    check("midrst_config", uart_bus.o_uart_config, 32'h070);
    core_en = 1'b0;
    #6 i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    check("postrst_rx_empty", o_rx_empty, 1);
    check("postrst_tx_valid", uart_bus.o_uart_tx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
